// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Data-hazard resolver sitting beside the ID stage. Checks up to NUM_SRC
//   source operands against the EX and MEM destinations (separate integer
//   and float register classes). It also keeps a per-float-register busy
//   scoreboard for long-latency FP ops, whose results never come from the
//   EX/MEM bypass paths.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   id_valid                         ID holds a real instruction
//   id_src_addr/used/float           per-source address, read enable, class
//   id_dst_addr/write/float          ID destination
//   id_fp_long                       ID is a long-latency FP op
//   ex_dst/write/float/is_load       EX destination info
//   mem_dst/write/float              MEM destination info
//   fw_sel                           per-source mux select (0 RF, 1 EX, 2 MEM)
//   stall                            freeze PC/IF/ID, bubble EX
//   sb_busy                          any scoreboard entry busy
//   stall_count                      saturating stalled-cycle counter
module hazard_scoreboard_unit #(
   parameter int AW      = 5,
   parameter int NUM_SRC = 3,
   parameter int FP_LAT  = 4,
   parameter int CW      = 3,
   parameter int SCW     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [NUM_SRC*AW-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]    id_src_used,
   input  logic [NUM_SRC-1:0]    id_src_float,
   input  logic [AW-1:0]         id_dst_addr,
   input  logic                  id_dst_write,
   input  logic                  id_dst_float,
   input  logic                  id_fp_long,
   input  logic [AW-1:0]         ex_dst,
   input  logic                  ex_write,
   input  logic                  ex_float,
   input  logic                  ex_is_load,
   input  logic [AW-1:0]         mem_dst,
   input  logic                  mem_write,
   input  logic                  mem_float,
   output logic [NUM_SRC*2-1:0]  fw_sel,
   output logic                  stall,
   output logic                  sb_busy,
   output logic [SCW-1:0]        stall_count
);

   localparam int NREG = 1 << AW;
   localparam logic [CW-1:0] LAT_INIT = CW'(FP_LAT);

   logic [CW-1:0]      sb_cnt [NREG];
   logic [NUM_SRC-1:0] ex_hit;
   logic [NUM_SRC-1:0] mem_hit;
   logic [NUM_SRC-1:0] raw_hit;
   logic               waw_hit;
   logic               load_use;
   logic               any_busy;
   logic               issue;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [AW-1:0] src;
      logic          rd;
      assign src = id_src_addr[i*AW +: AW];
      assign rd  = id_valid & id_src_used[i];
      // integer r0 is hardwired zero and never forwards; float f0 is real
      assign ex_hit[i]  = rd & ex_write & (ex_float == id_src_float[i]) &
                          (ex_dst == src) & (ex_float | (src != '0));
      assign mem_hit[i] = rd & mem_write & (mem_float == id_src_float[i]) &
                          (mem_dst == src) & (mem_float | (src != '0));
      assign raw_hit[i] = rd & id_src_float[i] & (sb_cnt[src] != '0);
   end

   assign waw_hit  = id_valid & id_dst_write & id_dst_float &
                     (sb_cnt[id_dst_addr] != '0);
   assign load_use = ex_is_load & (|ex_hit);

   always_comb begin
      any_busy = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         any_busy = any_busy | (sb_cnt[r] != '0);
      end
   end

   // All outputs are forced quiet while reset is asserted.
   assign stall   = rst_n & (load_use | waw_hit | (|raw_hit));
   assign sb_busy = rst_n & any_busy;
   assign issue   = id_valid & ~stall & id_fp_long & id_dst_write & id_dst_float;

   always_comb begin
      fw_sel = '0;
      if (rst_n && !stall) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_hit[i])       fw_sel[2*i +: 2] = 2'd1;
            else if (mem_hit[i]) fw_sel[2*i +: 2] = 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) sb_cnt[r] <= '0;
         stall_count <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (sb_cnt[r] != '0) sb_cnt[r] <= sb_cnt[r] - CW'(1);
         end
         // new issue overrides this entry's decrement
         if (issue) sb_cnt[id_dst_addr] <= LAT_INIT;
         if (stall && (stall_count != '1)) stall_count <= stall_count + SCW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: each step drives one ID cycle,
// pushes its expected outputs to a queue and pops/compares at the negedge.
module tb_hazard_scoreboard_unit;

   localparam int AW = 5, NS = 3, SCW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            id_valid = 1'b0;
   logic [NS*AW-1:0] id_src_addr = '0;
   logic [NS-1:0]   id_src_used = '0;
   logic [NS-1:0]   id_src_float = '0;
   logic [AW-1:0]   id_dst_addr = '0;
   logic            id_dst_write = 1'b0;
   logic            id_dst_float = 1'b0;
   logic            id_fp_long = 1'b0;
   logic [AW-1:0]   ex_dst = '0;
   logic            ex_write = 1'b0;
   logic            ex_float = 1'b0;
   logic            ex_is_load = 1'b0;
   logic [AW-1:0]   mem_dst = '0;
   logic            mem_write = 1'b0;
   logic            mem_float = 1'b0;
   logic [NS*2-1:0] fw_sel;
   logic            stall;
   logic            sb_busy;
   logic [SCW-1:0]  stall_count;

   hazard_scoreboard_unit #(.AW(AW), .NUM_SRC(NS), .FP_LAT(4), .CW(3), .SCW(SCW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
      .id_src_used(id_src_used), .id_src_float(id_src_float), .id_dst_addr(id_dst_addr),
      .id_dst_write(id_dst_write), .id_dst_float(id_dst_float), .id_fp_long(id_fp_long),
      .ex_dst(ex_dst), .ex_write(ex_write), .ex_float(ex_float), .ex_is_load(ex_is_load),
      .mem_dst(mem_dst), .mem_write(mem_write), .mem_float(mem_float),
      .fw_sel(fw_sel), .stall(stall), .sb_busy(sb_busy), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string          tag;
      logic [NS*2-1:0] fw;
      logic           st;
      logic           bz;
      logic [SCW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int cnt_model = 0;

   task automatic idle();
      id_valid = 1'b0; id_src_addr = '0; id_src_used = '0; id_src_float = '0;
      id_dst_addr = '0; id_dst_write = 1'b0; id_dst_float = 1'b0; id_fp_long = 1'b0;
      ex_dst = '0; ex_write = 1'b0; ex_float = 1'b0; ex_is_load = 1'b0;
      mem_dst = '0; mem_write = 1'b0; mem_float = 1'b0;
   endtask

   task automatic set_src(input int i, input int addr, input logic flt);
      id_valid = 1'b1;
      id_src_addr[i*AW +: AW] = AW'(addr);
      id_src_used[i] = 1'b1;
      id_src_float[i] = flt;
   endtask

   task automatic step(input string tag, input logic [NS*2-1:0] fw,
                       input logic st, input logic bz);
      exp_t e;
      e.tag = tag; e.fw = fw; e.st = st; e.bz = bz; e.cnt = SCW'(cnt_model);
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      checks++;
      assert (fw_sel === e.fw) else begin
         failures++;
         $error("FAIL %s fw_sel observed=%h expected=%h", e.tag, fw_sel, e.fw);
      end
      checks++;
      assert (stall === e.st) else begin
         failures++;
         $error("FAIL %s stall observed=%b expected=%b", e.tag, stall, e.st);
      end
      checks++;
      assert (sb_busy === e.bz) else begin
         failures++;
         $error("FAIL %s sb_busy observed=%b expected=%b", e.tag, sb_busy, e.bz);
      end
      checks++;
      assert (stall_count === e.cnt) else begin
         failures++;
         $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.cnt);
      end
      @(posedge clk);
      if (!rst_n) cnt_model = 0;
      else if (st && cnt_model != (1 << SCW) - 1) cnt_model++;
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // load-use hazard present while in reset: outputs must stay quiet
      set_src(0, 5, 1'b0); ex_dst = 5; ex_write = 1; ex_is_load = 1;
      step("reset_quiet", 6'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      idle(); set_src(0, 3, 0); set_src(1, 4, 0);
      ex_dst = 3; ex_write = 1; mem_dst = 4; mem_write = 1;
      step("fwd_indep", 6'b001001, 1'b0, 1'b0);

      idle(); set_src(0, 7, 0); ex_dst = 7; ex_write = 1; mem_dst = 7; mem_write = 1;
      step("ex_priority", 6'b000001, 1'b0, 1'b0);

      idle(); set_src(0, 0, 0); ex_dst = 0; ex_write = 1;
      step("int_zero", 6'b000000, 1'b0, 1'b0);

      idle(); set_src(2, 5, 0); set_src(0, 9, 0); mem_dst = 9; mem_write = 1;
      ex_dst = 5; ex_write = 1; ex_is_load = 1;
      step("load_use", 6'b000000, 1'b1, 1'b0);

      idle(); set_src(2, 5, 0); mem_dst = 5; mem_write = 1;
      step("load_next", 6'b100000, 1'b0, 1'b0);

      idle(); set_src(0, 6, 1); ex_dst = 6; ex_write = 1;
      step("class_sep", 6'b000000, 1'b0, 1'b0);

      idle(); set_src(0, 0, 1); ex_dst = 0; ex_write = 1; ex_float = 1;
      step("float_zero", 6'b000001, 1'b0, 1'b0);

      idle(); set_src(0, 5, 0); id_valid = 0; ex_dst = 5; ex_write = 1; ex_is_load = 1;
      step("id_invalid", 6'b000000, 1'b0, 1'b0);

      // long FP issue to f2 at t0
      idle(); id_valid = 1; id_fp_long = 1; id_dst_write = 1; id_dst_float = 1; id_dst_addr = 2;
      step("fp_issue_t0", 6'd0, 1'b0, 1'b0);
      idle(); set_src(0, 2, 1);
      step("raw_t1", 6'd0, 1'b1, 1'b1);
      idle(); id_valid = 1; id_dst_write = 1; id_dst_float = 1; id_dst_addr = 2;
      step("waw_t2", 6'd0, 1'b1, 1'b1);
      idle(); set_src(0, 2, 1);
      step("raw_t3", 6'd0, 1'b1, 1'b1);
      step("raw_t4", 6'd0, 1'b1, 1'b1);
      step("raw_t5_go", 6'd0, 1'b0, 1'b0);

      // reset in the middle of a busy f2
      idle(); id_valid = 1; id_fp_long = 1; id_dst_write = 1; id_dst_float = 1; id_dst_addr = 2;
      step("rst_issue", 6'd0, 1'b0, 1'b0);
      idle(); set_src(0, 2, 1);
      step("rst_busy_t1", 6'd0, 1'b1, 1'b1);
      rst_n = 1'b0;
      step("rst_t2", 6'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step("rst_t3_go", 6'd0, 1'b0, 1'b0);

      // hold a load-use stall long enough to saturate the 4-bit counter
      idle(); set_src(1, 8, 0); ex_dst = 8; ex_write = 1; ex_is_load = 1;
      for (int k = 0; k < 20; k++) step("sat_hold", 6'd0, 1'b1, 1'b0);
      idle();
      step("sat_final", 6'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-select forwarding unit.
- Resolves data hazards for up to NUM_SRC source operands per ID-stage instruction.
- Keeps separate integer and float register classes.
- Adds a registered scoreboard for long-latency FP operations that bypass the EX/MEM forwarding paths.
- Sits beside the ID stage; drives per-source operand muxes and the pipeline stall line.

Parameters:
- AW, 5, register address width (2^AW registers per class).
- NUM_SRC, 3, number of source operands checked per instruction.
- FP_LAT, 4, cycles a long-latency FP destination stays busy after issue (1..2^CW-1).
- CW, 3, scoreboard per-register counter width.
- SCW, 16, stall performance counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src_addr  in  NUM_SRC*AW  source addresses, source i at bits [i*AW +: AW].
- id_src_used  in  NUM_SRC  source i is actually read.
- id_src_float  in  NUM_SRC  source i is in the float class.
- id_dst_addr  in  AW  ID destination address.
- id_dst_write  in  1  ID writes a register.
- id_dst_float  in  1  ID destination is float.
- id_fp_long  in  1  ID is a long-latency FP op.
- ex_dst  in  AW  EX destination; ex_write, ex_float, ex_is_load  in  1 each.
- mem_dst  in  AW  MEM destination; mem_write, mem_float  in  1 each.
- fw_sel  out  NUM_SRC*2  per-source select: 0 = register file, 1 = EX result, 2 = MEM result, 3 = unused.
- stall  out  1  freeze PC/IF/ID, bubble EX.
- sb_busy  out  1  any scoreboard counter nonzero.
- stall_count  out  SCW  saturating count of stalled cycles.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n). On a clk edge with rst_n=0, all scoreboard counters and stall_count clear to 0.
- Outputs during reset: while rst_n=0, stall=0, fw_sel=0, sb_busy=0.
- Register-class match rule: source i matches stage X iff id_valid, id_src_used[i], X_write, X_float==id_src_float[i], and X_dst==src addr.
  - Integer address 0 never matches.
  - Float address 0 is a real register and does match.
- Forwarding: fw_sel is combinational and independent per source; several sources may forward in the same cycle.
  - EX match takes priority over MEM match (youngest wins).
  - No match gives 0.
- Load-use stall: any source matching EX with ex_is_load=1 raises stall.
- Scoreboard: one CW-bit counter per float register. Source i with id_src_float[i]=1 and a nonzero counter raises stall (RAW).
- FP WAW stall: id_dst_write & id_dst_float with a nonzero counter on id_dst_addr raises stall.
- Stall output: stall is the OR of all stall reasons. While stall=1, fw_sel is all 0.
- Scoreboard update, registered at the clk edge:
  - Every nonzero counter decrements by 1.
  - If id_valid & !stall & id_fp_long & id_dst_write & id_dst_float, then counter[id_dst_addr] loads FP_LAT. This load overrides the same-cycle decrement of that entry.
- Scoreboard latency: an issue in cycle t makes the register busy in cycles t+1 .. t+FP_LAT. The counter reads 0 at t+FP_LAT+1, and a dependent instruction proceeds in that cycle.
- Long-FP results: never taken from EX/MEM. The scoreboard owns them; the EX/MEM match logic still applies to short float ops.
- sb_busy: combinational OR of all counters.
- stall_count: increments on each clk edge with rst_n=1 and stall=1. It holds at 2^SCW-1 and does not wrap.
- Reset mid-operation: busy counters clear immediately. A dependent instruction present in the next cycle does not stall.
- id_valid=0: no stall, fw_sel 0, no scoreboard issue; counters still decrement.

Test Plan:
- Independent forwarding: ID src0=r3, src1=r4 (int); EX writes r3, MEM writes r4 -> fw_sel[1:0]=1, fw_sel[3:2]=2, stall=0.
- Priority and integer zero:
  - EX and MEM both write r7; src0=r7 -> sel 1.
  - src0=r0 with EX writing r0 -> sel 0.
- Load-use: EX is a load to r5, ID src2=r5 -> stall=1, fw_sel=0. Next cycle with EX a bubble and MEM writing r5 -> sel 2, stall=0.
- Scoreboard timing (FP_LAT=4): issue long FP to f2 at t0.
  - Reader of f2 stalls t1..t4 and proceeds at t5; stall_count increases by 4.
  - A write to f2 at t2 also stalls (WAW).
- Class separation: EX writes int r6; ID reads float f6 -> sel 0. EX writes float f0; ID reads float f0 -> sel 1.
- Reset and saturation:
  - rst_n=0 at t2 of a busy f2 -> counters 0, sb_busy=0 at t3, reader unstalled.
  - With SCW=4, hold stall for 20 cycles -> stall_count=15.
